// File: rtl/bus_gate_arbiter.sv
// Round-robin bus gate arbiter for four sources (MARMUX, PC, ALU, MDR).
// Optional hold-limit preemption is built when BUS_ARB_TIMEOUT_EN is defined.
//
// state | meaning
// IDLE  | no grant, gnt = 0, owner keeps the most recent grantee
// GRANT | gnt one-hot at bit owner
module bus_gate_arbiter #(
    parameter int MAX_HOLD = 8
) (
    input  logic       Clk,
    input  logic       Reset,
    input  logic [3:0] req,
    output logic [3:0] gnt,
    output logic       GateMARMUX,
    output logic       GatePC,
    output logic       GateALU,
    output logic       GateMDR,
    output logic       bus_busy,
    output logic [1:0] owner,
    output logic       timeout
);

    localparam logic IDLE  = 1'b0;
    localparam logic GRANT = 1'b1;

    if (MAX_HOLD < 2 || MAX_HOLD > 255) begin : g_bad_max_hold
        $error("bus_gate_arbiter: MAX_HOLD out of range 2..255");
    end

    logic       state, state_n;
    logic [3:0] gnt_n;
    logic [1:0] owner_n;
    logic       timeout_n;
    logic       preempt;

    logic       win_x_any;
    logic [1:0] win_x_idx;
    logic       win_any;
    logic [1:0] win_idx;

    // Rotating scan starting after the current owner; owner itself is checked last.
    always_comb begin
        logic [1:0] idx;
        win_x_any = 1'b0;
        win_x_idx = owner;
        for (int k = 3; k >= 1; k--) begin
            idx = owner + 2'(k);
            if (req[idx]) begin
                win_x_any = 1'b1;
                win_x_idx = idx;
            end
        end
        win_any = win_x_any | req[owner];
        win_idx = win_x_any ? win_x_idx : owner;
    end

`ifdef BUS_ARB_TIMEOUT_EN
    localparam logic [7:0] HOLD_LAST = 8'(MAX_HOLD - 1);

    logic [7:0] hold_cnt, hold_cnt_n;

    assign preempt = (state == GRANT) && (hold_cnt == HOLD_LAST) && win_x_any;

    always_comb begin
        hold_cnt_n = hold_cnt;
        if (state_n == GRANT && (owner_n != owner || state == IDLE || preempt))
            hold_cnt_n = 8'd0;
        else if (state_n == GRANT)
            hold_cnt_n = (hold_cnt == HOLD_LAST) ? hold_cnt : hold_cnt + 8'd1;
        else
            hold_cnt_n = 8'd0;
    end

    always_ff @(posedge Clk) begin
        if (Reset) hold_cnt <= 8'd0;
        else       hold_cnt <= hold_cnt_n;
    end
`else
    assign preempt = 1'b0;
`endif

    always_comb begin
        state_n   = state;
        gnt_n     = gnt;
        owner_n   = owner;
        timeout_n = 1'b0;
        case (state)
            IDLE: begin
                if (win_any) begin
                    state_n = GRANT;
                    owner_n = win_idx;
                    gnt_n   = 4'b0001 << win_idx;
                end
            end
            default: begin
                if (preempt) begin
                    owner_n   = win_x_idx;
                    gnt_n     = 4'b0001 << win_x_idx;
                    timeout_n = 1'b1;
                end else if (req[owner]) begin
                    gnt_n = 4'b0001 << owner;
                end else if (win_x_any) begin
                    owner_n = win_x_idx;
                    gnt_n   = 4'b0001 << win_x_idx;
                end else begin
                    state_n = IDLE;
                    gnt_n   = 4'b0000;
                end
            end
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state    <= IDLE;
            gnt      <= 4'b0000;
            owner    <= 2'd3;
            timeout  <= 1'b0;
            bus_busy <= 1'b0;
        end else begin
            state    <= state_n;
            gnt      <= gnt_n;
            owner    <= owner_n;
            timeout  <= timeout_n;
            bus_busy <= |gnt_n;
        end
    end

    assign GateMARMUX = gnt[3];
    assign GatePC     = gnt[2];
    assign GateALU    = gnt[1];
    assign GateMDR    = gnt[0];

endmodule

// File: tb/tb_bus_gate_arbiter.sv
// Directed-vector bench for bus_gate_arbiter (MAX_HOLD = 4); the hold-limit
// sequence expects preemption only when BUS_ARB_TIMEOUT_EN is defined.
module tb_bus_gate_arbiter;

    logic       Clk = 1'b0;
    logic       Reset;
    logic [3:0] req;
    logic [3:0] gnt;
    logic       GateMARMUX, GatePC, GateALU, GateMDR;
    logic       bus_busy;
    logic [1:0] owner;
    logic       timeout;

    int vectors = 0;
    int miscompares = 0;
    logic mon_en = 1'b0;

    bus_gate_arbiter #(.MAX_HOLD(4)) dut (
        .Clk(Clk), .Reset(Reset), .req(req), .gnt(gnt),
        .GateMARMUX(GateMARMUX), .GatePC(GatePC), .GateALU(GateALU), .GateMDR(GateMDR),
        .bus_busy(bus_busy), .owner(owner), .timeout(timeout)
    );

    always #5 Clk = ~Clk;

    typedef struct {
        logic       rst;
        logic [3:0] req;
        logic [3:0] gnt;
        logic [1:0] owner;
    } vec_t;

    vec_t tbl[19];

    task automatic check(input string name, input logic [3:0] eg, input logic [1:0] eo,
                         input logic et);
        logic [7:0] act, exp;
        act = {gnt, GateMARMUX, GatePC, GateALU, GateMDR};
        exp = {eg, eg};
        vectors++;
        if (act != exp || bus_busy != (eg != 4'b0000) || owner != eo || timeout != et) begin
            miscompares++;
            $display("FAIL %s: gnt=%b gates=%b busy=%b owner=%0d timeout=%b, required gnt=%b owner=%0d timeout=%b",
                     name, gnt, {GateMARMUX, GatePC, GateALU, GateMDR}, bus_busy, owner, timeout,
                     eg, eo, et);
        end
    endtask

    task automatic step(input logic r, input logic [3:0] q);
        Reset = r;
        req   = q;
        @(posedge Clk);
        #1;
    endtask

    always @(negedge Clk) begin
        if (mon_en) begin
            vectors++;
            if (!$onehot0(gnt)) begin
                miscompares++;
                $display("FAIL onehot: gnt=%b, required zero or one-hot", gnt);
            end
        end
    end

    initial begin
        tbl[0]  = '{1'b1, 4'b1111, 4'b0000, 2'd3};
        tbl[1]  = '{1'b0, 4'b1111, 4'b0001, 2'd0};
        tbl[2]  = '{1'b0, 4'b1110, 4'b0010, 2'd1};
        tbl[3]  = '{1'b0, 4'b1100, 4'b0100, 2'd2};
        tbl[4]  = '{1'b0, 4'b1001, 4'b1000, 2'd3};
        tbl[5]  = '{1'b0, 4'b0001, 4'b0001, 2'd0};
        tbl[6]  = '{1'b0, 4'b0000, 4'b0000, 2'd0};
        tbl[7]  = '{1'b0, 4'b0000, 4'b0000, 2'd0};
        tbl[8]  = '{1'b0, 4'b0100, 4'b0100, 2'd2};
        tbl[9]  = '{1'b0, 4'b0100, 4'b0100, 2'd2};
        tbl[10] = '{1'b0, 4'b0100, 4'b0100, 2'd2};
        tbl[11] = '{1'b0, 4'b0000, 4'b0000, 2'd2};
        tbl[12] = '{1'b0, 4'b1111, 4'b1000, 2'd3};
        tbl[13] = '{1'b0, 4'b0111, 4'b0001, 2'd0};
        tbl[14] = '{1'b0, 4'b0010, 4'b0010, 2'd1};
        tbl[15] = '{1'b1, 4'b1111, 4'b0000, 2'd3};
        tbl[16] = '{1'b0, 4'b1111, 4'b0001, 2'd0};
        tbl[17] = '{1'b0, 4'b0011, 4'b0001, 2'd0};
        tbl[18] = '{1'b0, 4'b0000, 4'b0000, 2'd0};

        Reset = 1'b1;
        req   = 4'b0000;
        @(posedge Clk);
        #1;
        mon_en = 1'b1;

        for (int i = 0; i < 19; i++) begin
            step(tbl[i].rst, tbl[i].req);
            check($sformatf("vec%0d", i), tbl[i].gnt, tbl[i].owner, 1'b0);
        end

        // Hold limit: MARMUX owns the bus while MDR waits from grant cycle 1.
        step(1'b0, 4'b1000);
        check("hold_c0", 4'b1000, 2'd3, 1'b0);
        for (int k = 1; k <= 3; k++) begin
            step(1'b0, 4'b1001);
            check($sformatf("hold_c%0d", k), 4'b1000, 2'd3, 1'b0);
        end
`ifdef BUS_ARB_TIMEOUT_EN
        step(1'b0, 4'b1001);
        check("preempt", 4'b0001, 2'd0, 1'b1);
        step(1'b0, 4'b1001);
        check("preempt_after", 4'b0001, 2'd0, 1'b0);
        step(1'b0, 4'b0000);
        check("preempt_idle", 4'b0000, 2'd0, 1'b0);
`else
        for (int k = 4; k < 10; k++) begin
            step(1'b0, 4'b1001);
            check($sformatf("nopreempt_c%0d", k), 4'b1000, 2'd3, 1'b0);
        end
        step(1'b0, 4'b0001);
        check("release_to_mdr", 4'b0001, 2'd0, 1'b0);
        step(1'b0, 4'b0000);
        check("release_idle", 4'b0000, 2'd0, 1'b0);
`endif

        // A lone requester keeps the bus past the hold limit.
        for (int k = 0; k < 8; k++) begin
            step(1'b0, 4'b0010);
            check($sformatf("alone_c%0d", k), 4'b0010, 2'd1, 1'b0);
        end
        step(1'b0, 4'b0000);
        check("alone_idle", 4'b0000, 2'd1, 1'b0);

        mon_en = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/bus_gate_arbiter.md
BUS_GATE_ARBITER -- requirements
Module: bus_gate_arbiter

Interface
REQ-001 Parameter MAX_HOLD, default 8, maximum consecutive grant cycles for one owner when others wait; legal range 2..255.
REQ-002 Clk  input  1  system clock; all state updates on its rising edge.
REQ-003 Reset  input  1  synchronous, active-high reset.
REQ-004 req  input  4  bus requests; bit3 MARMUX, bit2 PC, bit1 ALU, bit0 MDR.
REQ-005 gnt  output  4  registered grant vector, same bit mapping as req; zero or one-hot.
REQ-006 GateMARMUX, GatePC, GateALU, GateMDR  output  1 each  bus gate enables, equal to gnt[3], gnt[2], gnt[1], gnt[0].
REQ-007 bus_busy  output  1  high whenever gnt is nonzero.
REQ-008 owner  output  2  index of the current or most recent grantee.
REQ-009 timeout  output  1  one-cycle pulse marking a forced preemption.

Function
REQ-010 The block SHALL use two states: IDLE (gnt = 0) and GRANT (gnt one-hot at bit owner).
REQ-011 gnt SHALL never have more than one bit set, in any cycle.
REQ-012 All outputs SHALL be registered; request-to-grant latency SHALL be exactly one cycle.
REQ-013 The winner SHALL be the first set req bit found scanning indices owner+1, owner+2, owner+3, owner (mod 4).
REQ-014 IDLE, req nonzero: next state GRANT, owner <= winner, gnt <= one-hot(winner).
REQ-015 IDLE, req zero: stay IDLE; gnt stays 0; owner holds its value.
REQ-016 GRANT, req[owner] high, no preemption: hold gnt and owner unchanged.
REQ-017 GRANT, req[owner] low, other req bits set: grant the next winner on the following edge (direct handoff, no idle bubble); stay GRANT.
REQ-018 GRANT, req[owner] low, req zero: go IDLE; gnt <= 0.
REQ-019 Req bits raised or dropped in the same cycle SHALL be sampled together; only the value at the edge matters.
REQ-020 Grantees SHALL receive no acknowledgement beyond gnt; a requester holding req with gnt low keeps waiting.

Reset
REQ-021 Reset SHALL win over all other inputs at the edge.
REQ-022 Reset SHALL force IDLE, gnt = 0, all Gate* = 0, bus_busy = 0, owner = 3, timeout = 0, hold counter = 0.
REQ-023 Reset asserted mid-grant SHALL drop gnt on that edge; the first grant after reset SHALL favour MDR (index 0).

Configuration
REQ-024 Macro BUS_ARB_TIMEOUT_EN, when defined, SHALL enable a hold counter: cleared on every new grant, incremented each GRANT cycle, saturating at MAX_HOLD-1.
REQ-025 With BUS_ARB_TIMEOUT_EN: if the counter is at MAX_HOLD-1 and another req bit is set, the next edge SHALL grant the next winner excluding owner, even if req[owner] is high.
REQ-026 With BUS_ARB_TIMEOUT_EN: timeout SHALL pulse high for exactly that one cycle, coincident with the new gnt.
REQ-027 With BUS_ARB_TIMEOUT_EN: if no other requester waits, the owner SHALL keep the bus and the counter SHALL stay saturated.
REQ-028 Without BUS_ARB_TIMEOUT_EN: no counter SHALL exist, timeout SHALL be tied 0, and an owner SHALL keep the bus until it drops req.

Verification
REQ-029 Reset, then req=4'b1111 -> next cycle gnt=4'b0001, GateMDR=1, owner=0, bus_busy=1.
REQ-030 Owner 0 drops req while req=4'b1110 -> next cycle gnt=4'b0010; continued release order 0100, 1000, then 0001 if pending; no zero-gnt bubble between grants.
REQ-031 Single req=4'b0100 for 3 cycles, then 4'b0000 -> gnt=0100 for 3 cycles starting one cycle after req, then gnt=0, bus_busy=0.
REQ-032 BUS_ARB_TIMEOUT_EN defined, MAX_HOLD=4, req=4'b1000 held, req[0] raised at grant cycle 1 -> gnt=1000 for 4 cycles, then gnt=0001 with a one-cycle timeout=1.
REQ-033 Macro undefined, same stimulus -> gnt stays 1000 until req[3] drops; timeout never asserts.
REQ-034 Reset asserted while gnt=0010 with req=4'b1111 -> next cycle gnt=0, owner=3; after release -> gnt=0001; one-hot checked every cycle.
